// File: rtl/loader_pkg.sv
//------------------------------------------------------------------------------
// loader_pkg
//   Shared framing constants and FSM state type for the program loader.
//   Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package loader_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_LEN_HI  = 4'd1,
    ST_LEN_LO  = 4'd2,
    ST_DATA_HI = 4'd3,
    ST_DATA_LO = 4'd4,
    ST_WRITE   = 4'd5,
    ST_CHECK   = 4'd6,
    ST_DONE    = 4'd7,
    ST_ERROR   = 4'd8
  } loader_state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int unsigned LEN_FIELD_W = 16;
  localparam int unsigned CHK_W       = 8;

  // The inter-byte timeout only applies once a frame has started and before it resolves.
  function automatic logic timer_active(input loader_state_t s);
    return (s >= ST_LEN_HI) && (s <= ST_CHECK);
  endfunction

endpackage

`default_nettype wire

// File: rtl/gap_timer.sv
//------------------------------------------------------------------------------
// gap_timer
//   Counts idle clocks while enabled; expired is high once GAP_LIMIT is reached.
//   Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module gap_timer #(
  parameter int unsigned GAP_LIMIT = 50000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = $clog2(GAP_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(GAP_LIMIT);

  logic [CW-1:0] count_q, count_d;

  // Saturates at the limit so expired stays asserted until cleared.
  always_comb begin
    count_d = count_q;
    if (clear || !enable) begin
      count_d = '0;
    end else if (count_q != LIMIT) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == LIMIT);

endmodule

`default_nettype wire

// File: rtl/prog_loader.sv
//------------------------------------------------------------------------------
// prog_loader
//   Unpacks a framed byte stream into big-endian 16-bit program words and
//   releases the CPU only after a frame passes its length and checksum checks.
//   Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module prog_loader
  import loader_pkg::*;
#(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned GAP_LIMIT = 50000,
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [15:0] prog_address,
  output logic [15:0] prog_data,
  output logic        prog_wren,
  output logic        cpu_run,
  output logic        load_error,
  output logic [15:0] word_count
);

  localparam logic [15:0] DEPTH_W = 16'(DEPTH);

  loader_state_t state_q, state_d;
  logic [15:0]   len_q, len_d;
  logic [7:0]    hi_q, hi_d;
  logic [7:0]    checksum_q, checksum_d;
  logic [15:0]   word_count_q, word_count_d;
  logic [15:0]   prog_address_q, prog_address_d;
  logic [15:0]   prog_data_q, prog_data_d;
  logic          prog_wren_q, prog_wren_d;
  logic          cpu_run_q, cpu_run_d;
  logic          load_error_q, load_error_d;

  logic          xfer;
  logic          timer_en;
  logic          timer_expired;
  logic [15:0]   len_next;
  logic [15:0]   count_inc;

  assign rx_ready  = (state_q != ST_WRITE);
  assign xfer      = rx_valid & rx_ready;
  assign timer_en  = timer_active(state_q);
  assign len_next  = {len_q[15:8], rx_data};
  assign count_inc = word_count_q + 16'd1;

  gap_timer #(
    .GAP_LIMIT (GAP_LIMIT)
  ) u_gap_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (xfer),
    .enable  (timer_en),
    .expired (timer_expired)
  );

  always_comb begin
    state_d        = state_q;
    len_d          = len_q;
    hi_d           = hi_q;
    checksum_d     = checksum_q;
    word_count_d   = word_count_q;
    prog_address_d = prog_address_q;
    prog_data_d    = prog_data_q;
    prog_wren_d    = 1'b0;
    cpu_run_d      = cpu_run_q;
    load_error_d   = load_error_q;

    // An accepted byte always takes priority over a coincident timeout.
    if (xfer) begin
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (rx_data == SYNC_BYTE) begin
            state_d        = ST_LEN_HI;
            checksum_d     = '0;
            word_count_d   = '0;
            prog_address_d = '0;
            cpu_run_d      = 1'b0;
          end
        end
        ST_LEN_HI: begin
          len_d   = {rx_data, 8'h00};
          state_d = ST_LEN_LO;
        end
        ST_LEN_LO: begin
          len_d = len_next;
          if (len_next == 16'd0) begin
            state_d = ST_CHECK;
          end else if (len_next > DEPTH_W) begin
            state_d = ST_ERROR;
          end else begin
            state_d = ST_DATA_HI;
          end
        end
        ST_DATA_HI: begin
          hi_d       = rx_data;
          checksum_d = checksum_q + rx_data;
          state_d    = ST_DATA_LO;
        end
        ST_DATA_LO: begin
          prog_data_d    = {hi_q, rx_data};
          prog_address_d = word_count_q;
          prog_wren_d    = 1'b1;
          checksum_d     = checksum_q + rx_data;
          state_d        = ST_WRITE;
        end
        ST_CHECK: begin
          if (rx_data == checksum_q) begin
            state_d      = ST_DONE;
            cpu_run_d    = 1'b1;
            load_error_d = 1'b0;
          end else begin
            state_d = ST_ERROR;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q == ST_WRITE) begin
      word_count_d = count_inc;
      state_d      = (count_inc == len_q) ? ST_CHECK : ST_DATA_HI;
    end else if (timer_en && timer_expired) begin
      state_d = ST_ERROR;
    end

    if (state_d == ST_ERROR) begin
      cpu_run_d    = 1'b0;
      load_error_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      len_q          <= '0;
      hi_q           <= '0;
      checksum_q     <= '0;
      word_count_q   <= '0;
      prog_address_q <= '0;
      prog_data_q    <= '0;
      prog_wren_q    <= 1'b0;
      cpu_run_q      <= 1'b0;
      load_error_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      len_q          <= len_d;
      hi_q           <= hi_d;
      checksum_q     <= checksum_d;
      word_count_q   <= word_count_d;
      prog_address_q <= prog_address_d;
      prog_data_q    <= prog_data_d;
      prog_wren_q    <= prog_wren_d;
      cpu_run_q      <= cpu_run_d;
      load_error_q   <= load_error_d;
    end
  end

  assign prog_address = prog_address_q;
  assign prog_data    = prog_data_q;
  assign prog_wren    = prog_wren_q;
  assign cpu_run      = cpu_run_q;
  assign load_error   = load_error_q;
  assign word_count   = word_count_q;

endmodule

`default_nettype wire

// File: tb/tb_prog_loader.sv
//------------------------------------------------------------------------------
// tb_prog_loader
//   Self-checking bench for prog_loader with a write scoreboard.
//   Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_prog_loader;

  localparam int GAP = 200;
  localparam logic [7:0] SYNC = 8'hA5;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [15:0] prog_address;
  logic [15:0] prog_data;
  logic        prog_wren;
  logic        cpu_run;
  logic        load_error;
  logic [15:0] word_count;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;

  always #5 clk = ~clk;

  prog_loader #(
    .DEPTH     (1024),
    .GAP_LIMIT (GAP),
    .SYNC_BYTE (SYNC)
  ) dut (
    .clock        (clk),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .prog_address (prog_address),
    .prog_data    (prog_data),
    .prog_wren    (prog_wren),
    .cpu_run      (cpu_run),
    .load_error   (load_error),
    .word_count   (word_count)
  );

  // Scoreboard: every write strobe must match the oldest expected (address, word).
  always @(negedge clk) begin
    total++;
    if (rx_ready !== ~prog_wren) begin
      bad++;
      $display("FAIL ready_vs_write: rx_ready=%b prog_wren=%b want rx_ready=!prog_wren", rx_ready, prog_wren);
    end
    if (prog_wren === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: got addr=%h data=%h want none", prog_address, prog_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({prog_address, prog_data} !== mon_exp) begin
          bad++;
          $display("FAIL write: got addr=%h data=%h want addr=%h data=%h",
                   prog_address, prog_data, mon_exp[31:16], mon_exp[15:0]);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1, "watchdog expired");
  end

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int idle;
    int guard;
    idle  = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    guard = 0;
    repeat (idle) @(negedge clk);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    while (rx_ready !== 1'b1 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 10) begin
      total++;
      bad++;
      $display("FAIL rx_ready_timeout: got rx_ready=%b want 1", rx_ready);
    end
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] words[$], input logic [7:0] chk_delta, input int max_gap);
    logic [7:0] sum;
    int n;
    sum = 8'h00;
    n   = words.size();
    send_byte(SYNC, max_gap);
    send_byte(8'(n >> 8), max_gap);
    send_byte(8'(n), max_gap);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({16'(i), words[i]});
      sum = sum + words[i][15:8] + words[i][7:0];
      send_byte(words[i][15:8], max_gap);
      send_byte(words[i][7:0], max_gap);
    end
    send_byte(sum + chk_delta, max_gap);
    repeat (2) @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset    = 1'b1;
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    total += 7;
    if (rx_ready !== 1'b1)       begin bad++; $display("FAIL rst_ready: got %b want 1", rx_ready); end
    if (prog_wren !== 1'b0)      begin bad++; $display("FAIL rst_wren: got %b want 0", prog_wren); end
    if (prog_address !== 16'h0)  begin bad++; $display("FAIL rst_addr: got %h want 0", prog_address); end
    if (prog_data !== 16'h0)     begin bad++; $display("FAIL rst_data: got %h want 0", prog_data); end
    if (cpu_run !== 1'b0)        begin bad++; $display("FAIL rst_run: got %b want 0", cpu_run); end
    if (load_error !== 1'b0)     begin bad++; $display("FAIL rst_err: got %b want 0", load_error); end
    if (word_count !== 16'h0)    begin bad++; $display("FAIL rst_count: got %h want 0", word_count); end
  endtask

  task automatic test_good_frame();
    logic [15:0] w[$];
    w = '{16'h2000, 16'h0007};
    send_byte(8'h3C, 0);  // junk before sync is dropped
    send_frame(w, 8'h00, 0);
    total += 4;
    if (cpu_run !== 1'b1)       begin bad++; $display("FAIL good_run: got %b want 1", cpu_run); end
    if (load_error !== 1'b0)    begin bad++; $display("FAIL good_err: got %b want 0", load_error); end
    if (word_count !== 16'd2)   begin bad++; $display("FAIL good_count: got %0d want 2", word_count); end
    if (exp_q.size() != 0)      begin bad++; $display("FAIL good_pending: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_bad_checksum();
    logic [15:0] w[$];
    w = '{16'h2000, 16'h0007};
    send_frame(w, 8'h01, 0);
    total += 3;
    if (load_error !== 1'b1)    begin bad++; $display("FAIL badchk_err: got %b want 1", load_error); end
    if (cpu_run !== 1'b0)       begin bad++; $display("FAIL badchk_run: got %b want 0", cpu_run); end
    if (exp_q.size() != 0)      begin bad++; $display("FAIL badchk_pending: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_length_bounds();
    logic [15:0] w[$];
    w = {};
    send_frame(w, 8'h00, 0);
    total += 3;
    if (cpu_run !== 1'b1)       begin bad++; $display("FAIL len0_run: got %b want 1", cpu_run); end
    if (load_error !== 1'b0)    begin bad++; $display("FAIL len0_err: got %b want 0", load_error); end
    if (word_count !== 16'd0)   begin bad++; $display("FAIL len0_count: got %0d want 0", word_count); end
    send_byte(SYNC, 0);
    total++;
    if (cpu_run !== 1'b0)       begin bad++; $display("FAIL reload_run: got %b want 0", cpu_run); end
    send_byte(8'hFF, 0);
    send_byte(8'hFF, 0);
    @(negedge clk);
    total++;
    if (load_error !== 1'b1)    begin bad++; $display("FAIL lenmax_err: got %b want 1", load_error); end
    // Exactly DEPTH words is legal; DEPTH+1 is rejected.
    send_frame(w, 8'h00, 0);
    send_byte(SYNC, 0);
    send_byte(8'h04, 0);
    send_byte(8'h00, 0);
    @(negedge clk);
    total++;
    if (load_error !== 1'b0)    begin bad++; $display("FAIL len1024_err: got %b want 0", load_error); end
    apply_reset();
    send_byte(SYNC, 0);
    send_byte(8'h04, 0);
    send_byte(8'h01, 0);
    @(negedge clk);
    total++;
    if (load_error !== 1'b1)    begin bad++; $display("FAIL len1025_err: got %b want 1", load_error); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] w[$];
    w = '{16'h1234, 16'hABCD, 16'hFFFF, 16'h0001, 16'h8080, 16'h55AA};
    send_frame(w, 8'h00, 0);
    w = '{16'hDEAD, 16'hBEEF, 16'h0F0F, 16'hF00D, 16'h7E7E, 16'h0000};
    send_frame(w, 8'h00, 3);
    total += 4;
    if (cpu_run !== 1'b1)       begin bad++; $display("FAIL b2b_run: got %b want 1", cpu_run); end
    if (load_error !== 1'b0)    begin bad++; $display("FAIL b2b_err: got %b want 0", load_error); end
    if (word_count !== 16'd6)   begin bad++; $display("FAIL b2b_count: got %0d want 6", word_count); end
    if (exp_q.size() != 0)      begin bad++; $display("FAIL b2b_pending: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_timeout();
    send_byte(SYNC, 0);
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    repeat (GAP + 5) @(negedge clk);
    total += 2;
    if (load_error !== 1'b1)    begin bad++; $display("FAIL timeout_err: got %b want 1", load_error); end
    if (cpu_run !== 1'b0)       begin bad++; $display("FAIL timeout_run: got %b want 0", cpu_run); end
    // A stall just under the limit must not abort the frame.
    send_byte(SYNC, 0);
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    repeat (GAP - 10) @(negedge clk);
    exp_q.push_back({16'h0000, 16'h1234});
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    send_byte(8'h46, 0);
    repeat (2) @(negedge clk);
    total += 3;
    if (load_error !== 1'b0)    begin bad++; $display("FAIL nearlimit_err: got %b want 0", load_error); end
    if (cpu_run !== 1'b1)       begin bad++; $display("FAIL nearlimit_run: got %b want 1", cpu_run); end
    if (exp_q.size() != 0)      begin bad++; $display("FAIL nearlimit_pending: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] w[$];
    w = '{16'h0BAD};
    send_frame(w, 8'h01, 0);  // leaves load_error=1 and nonzero prog_data
    exp_q.push_back({16'h0000, 16'h2000});
    send_byte(SYNC, 0);
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'h20, 0);
    void'(exp_q.pop_back());
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total += 6;
    if (rx_ready !== 1'b1)      begin bad++; $display("FAIL midrst_ready: got %b want 1", rx_ready); end
    if (prog_wren !== 1'b0)     begin bad++; $display("FAIL midrst_wren: got %b want 0", prog_wren); end
    if (prog_data !== 16'h0)    begin bad++; $display("FAIL midrst_data: got %h want 0", prog_data); end
    if (cpu_run !== 1'b0)       begin bad++; $display("FAIL midrst_run: got %b want 0", cpu_run); end
    if (load_error !== 1'b0)    begin bad++; $display("FAIL midrst_err: got %b want 0", load_error); end
    if (word_count !== 16'h0)   begin bad++; $display("FAIL midrst_count: got %h want 0", word_count); end
    w = '{16'hC0DE, 16'h0102, 16'h0304};
    send_frame(w, 8'h00, 1);
    total += 3;
    if (cpu_run !== 1'b1)       begin bad++; $display("FAIL reload_run2: got %b want 1", cpu_run); end
    if (word_count !== 16'd3)   begin bad++; $display("FAIL reload_count: got %0d want 3", word_count); end
    if (exp_q.size() != 0)      begin bad++; $display("FAIL reload_pending: got %0d want 0", exp_q.size()); end
  endtask

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_length_bounds();
    test_back_to_back();
    test_timeout();
    test_reset_mid_frame();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
